// File: rtl/cache_fill_ctrl_if.sv
// Memory read port of the cache fill controller.
// Handshake: mem_en is a fire-and-forget read request that memory always
// accepts in the cycle it is raised, with mem_addr valid alongside it.
// mem_vld carries one returned word per cycle in mem_data. Words return in
// issue order with arbitrary latency and gaps. There is no back-pressure in
// either direction.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_vld;

  modport master (output mem_en, output mem_addr, input mem_data, input mem_vld);
  modport slave  (input mem_en, input mem_addr, output mem_data, output mem_vld);
endinterface

// File: rtl/cache_fill_ctrl.sv
// Shared I/D cache miss handler. It arbitrates misses with I first, then
// bursts one block from memory. Each returned word is written into the owning
// cache, and the tag is committed with the last word. Issue and receive use
// separate counters, so any memory latency is tolerated.
module cache_fill_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int WORD_BYTES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              miss_d,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic              hold,
  cache_fill_ctrl_if.master mem,
  output logic [DATA_W-1:0] fill_data,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              fill_we_i,
  output logic              fill_we_d,
  output logic              tag_we_i,
  output logic              tag_we_d,
  output logic              stall,
  output logic              idle,
  output logic [1:0]        dbg_state
);

  localparam int OFS   = $clog2(BLOCK_WORDS * WORD_BYTES);
  localparam int WB_SH = $clog2(WORD_BYTES);
  localparam int CW    = $clog2(BLOCK_WORDS) + 1;

  localparam logic [CW-1:0]     CNT_FULL  = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFS;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL_I = 2'd1;
  localparam logic [1:0] S_FILL_D = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0]     iss_cnt;
  logic [CW-1:0]     rcv_cnt;

  logic              in_fill;
  logic              issue;
  logic              rcv;
  logic              last_word;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] rcv_addr;

  // Datapath decode: issue side, receive side, and the cache write strobes.
  always_comb begin
    in_fill   = (state == S_FILL_I) || (state == S_FILL_D);
    issue     = in_fill && (iss_cnt < CNT_FULL);
    iss_addr  = base + (ADDR_W'(iss_cnt) << WB_SH);
    rcv_addr  = base + (ADDR_W'(rcv_cnt) << WB_SH);
    // A word that arrives outside a fill is dropped here.
    rcv       = in_fill && mem.mem_vld;
    last_word = rcv && (rcv_cnt == CNT_LAST);
    fill_we_i = rcv && (state == S_FILL_I);
    fill_we_d = rcv && (state == S_FILL_D);
    tag_we_i  = last_word && (state == S_FILL_I);
    tag_we_d  = last_word && (state == S_FILL_D);
    fill_data = rcv ? mem.mem_data : '0;
    fill_addr = rcv ? rcv_addr : '0;
    // Stall in IDLE as soon as a miss or hold appears, before the FSM moves.
    stall     = (state != S_IDLE) || miss_i || miss_d || hold;
    idle      = (state == S_IDLE);
    dbg_state = state;
  end

  assign mem.mem_en   = issue;
  assign mem.mem_addr = in_fill ? iss_addr : '0;

  // Fill FSM with the block base and the issue/receive counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      base    <= '0;
      iss_cnt <= '0;
      rcv_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          iss_cnt <= '0;
          rcv_cnt <= '0;
          if (hold) begin
            state <= S_WAIT;
          end else if (miss_i) begin
            state <= S_FILL_I;
            base  <= addr_i & BASE_MASK;
          end else if (miss_d) begin
            state <= S_FILL_D;
            base  <= addr_d & BASE_MASK;
          end
        end
        S_FILL_I, S_FILL_D: begin
          if (issue) iss_cnt <= iss_cnt + 1'b1;
          if (rcv)   rcv_cnt <= rcv_cnt + 1'b1;
          if (last_word) begin
            // A pending D miss follows an I fill directly, with no IDLE cycle.
            if ((state == S_FILL_I) && miss_d) begin
              state   <= S_FILL_D;
              base    <= addr_d & BASE_MASK;
              iss_cnt <= '0;
              rcv_cnt <= '0;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Parametrised miss handler shared by the instruction and data caches. It arbitrates simultaneous I/D misses with I first, then fetches one cache block from the multi-cycle memory as a pipelined burst. It writes each returned word into the owning cache's data array and commits the tag on the last word. Compared with the previous controller, block size, address width and data width are parameters, and issue and receive are tracked by separate counters, so any memory latency is tolerated.

## Interface
- ADDR_W, 16, byte-address width.
- DATA_W, 16, memory/cache word width.
- BLOCK_WORDS, 8, words per cache block; a power of two, at least 2.
- WORD_BYTES, 2, byte stride between words; a power of two.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- miss_i  in  1  I-cache miss, level, held until its tag is written.
- addr_i  in  ADDR_W  I-cache miss address.
- miss_d  in  1  D-cache miss, level.
- addr_d  in  ADDR_W  D-cache miss address.
- hold  in  1  blocks the start of a new fill.
- mem_en  out  1  issue a read to memory this cycle.
- mem_addr  out  ADDR_W  read address issued with mem_en.
- mem_data  in  DATA_W  returned word.
- mem_vld  in  1  mem_data is valid; words return in issue order.
- fill_data  out  DATA_W  word to write into the cache.
- fill_addr  out  ADDR_W  cache address of fill_data.
- fill_we_i / fill_we_d  out  1 each  data-array write enable, I or D.
- tag_we_i / tag_we_d  out  1 each  metadata write enable, I or D.
- stall  out  1  pipeline stall.
- idle  out  1  FSM is in IDLE.

## Operation
- OFS = log2(BLOCK_WORDS*WORD_BYTES). Block base = miss address with the low OFS bits cleared.
- Registers:
  - state
  - base (ADDR_W)
  - iss_cnt and rcv_cnt, each log2(BLOCK_WORDS)+1 bits
- States and transitions:
  - IDLE:
    - hold=1 → WAIT.
    - Otherwise miss_i → FILL_I, latching base from addr_i.
    - Otherwise miss_d → FILL_D, latching base from addr_d.
    - Otherwise stay in IDLE.
    - Counters are cleared on every IDLE cycle.
  - FILL_I / FILL_D:
    - mem_en = (iss_cnt < BLOCK_WORDS).
    - mem_addr = base + iss_cnt*WORD_BYTES; iss_cnt increments when mem_en=1.
    - On mem_vld: fill_data = mem_data, fill_addr = base + rcv_cnt*WORD_BYTES, the owning fill_we_* pulses, and rcv_cnt increments.
    - The last word is the one received when rcv_cnt == BLOCK_WORDS-1. On that cycle the owning tag_we_* pulses together with fill_we_*.
  - End of FILL_I:
    - If miss_d is sampled high on the last-word cycle → FILL_D directly. base is reloaded from addr_d and both counters clear.
    - Otherwise → WAIT.
  - End of FILL_D → WAIT.
  - WAIT: a single cycle, then → IDLE. This lets the caches re-evaluate hit.
- stall = (state != IDLE) | (IDLE & (miss_i | miss_d | hold)).
- idle = (state == IDLE).
- All fill and tag enables are 0 outside the matching FILL state.
- fill_data/fill_addr are 0 when no fill_we_* is high.
- mem_vld outside FILL states is ignored and changes no counter.
- mem_addr is base + iss_cnt*WORD_BYTES in FILL states and 0 otherwise.
- Address arithmetic is modulo 2^ADDR_W; there is no carry out of the block because base is aligned.

## Timing
- Reset (asynchronous, takes effect immediately) gives:
  - state IDLE, base 0, counters 0.
  - mem_en 0, mem_addr 0.
  - all we 0, fill_data/fill_addr 0.
  - stall 0 (inputs low), idle 1.
- Reset asserted mid-fill aborts it; no tag_we is produced.
- Miss seen in IDLE at cycle 0 → stall=1 combinationally in cycle 0; first mem_en in cycle 1.
- Issue is back-to-back: mem_en is high for cycles 1..BLOCK_WORDS.
- With memory latency L, the last word returns in cycle BLOCK_WORDS+L-1+... and the tag is written on that cycle. The FSM is in WAIT on the next cycle and in IDLE with stall released on the one after, provided the miss has dropped.
- Memory may stretch gaps in mem_vld arbitrarily; only ordering is required.
- Simultaneous miss_i and miss_d in IDLE: the I fill runs first, then D with no IDLE cycle between.
- hold wins over misses in IDLE.

## Test plan
- Reset with defaults → idle=1, stall=0, mem_en=0, every output 0; release with no miss → stays idle.
- miss_i, addr_i=0x1236, memory L=4 returning 0xA0..0xA7 → mem_addr 0x1230,0x1232,…,0x123E on 8 consecutive cycles. fill_we_i 8 times at 0x1230..0x123E with matching data. tag_we_i with the 8th word. stall released two cycles later.
- miss_i at 0x0040 and miss_d at 0x8012 together → full I fill, then FILL_D at base 0x8010 immediately, tag_we_d once; fill_we_i is never high during FILL_D.
- FILL_D with mem_vld gaps (pattern 1,0,0,1,…) → rcv_cnt advances only on vld, fill_addr stays contiguous, tag_we_d only on the 8th word.
- hold=1 with miss_d=1 in IDLE → WAIT then IDLE, mem_en=0 throughout; after hold drops the D fill starts.
- rst_n pulsed low after the 3rd word of an I fill → immediate idle=1, no tag_we_i; the next miss restarts at word 0. Repeat the fill case with BLOCK_WORDS=4, ADDR_W=20.
